// File: rtl/signed_entry_pkg.sv
// Shared types and constants for the signed-entry keypad block.
package signed_entry_pkg;

  localparam int DATA_W = 4;
  localparam logic [DATA_W-1:0] MAX_POS     = 4'd7;
  localparam logic [DATA_W-1:0] MAX_NEG_MAG = 4'd8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EDIT   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Sign/magnitude to two's complement; -0 maps to 0 and -8 to 4'b1000.
  function automatic logic [DATA_W-1:0] to_twos(input logic [DATA_W-1:0] m,
                                                input logic              n);
    return n ? (~m + 1'b1) : m;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer, debounce filter and press-edge detector for one
// active-low pushbutton. level is the accepted (debounced) level, press is a
// one-cycle pulse on an accepted 1->0 transition.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous button into the clock domain; idle level is 1.
  // NOTE: sequential state always uses non-blocking (<=) so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Accept a new level after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level <= s2;
        cnt   <= '0;
        press <= ~s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/signed_entry.sv
// Signed value entry from two pushbuttons (step, enter) and a sign switch.
// Optional feature: define SIGNED_ENTRY_AUTOREPEAT_EN to make a held step key
// repeat every REPEAT_CYCLES cycles while editing.
module signed_entry
  import signed_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_CYCLES   = 12500000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        key_n,
  input  logic              sign_sw,
  output logic [DATA_W-1:0] mag,
  output logic              neg,
  output logic              editing,
  output logic [DATA_W-1:0] value,
  output logic              valid
);

  state_t            state;
  logic              step_lvl;
  logic              step_ev;
  logic              enter_lvl;
  logic              enter_ev;
  logic              step_go;
  logic              sign_s1;
  logic              sign_s2;
  logic [DATA_W-1:0] mag_base;
  logic [DATA_W-1:0] mag_limit;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (key_n[0]),
    .level (step_lvl),
    .press (step_ev)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (key_n[1]),
    .level (enter_lvl),
    .press (enter_ev)
  );

  // Synchronize the sign switch; it resets to positive to match neg.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_s1 <= 1'b0;
      sign_s2 <= 1'b0;
    end else begin
      sign_s1 <= sign_sw;
      sign_s2 <= sign_s1;
    end
  end

`ifdef SIGNED_ENTRY_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
  logic [REP_W-1:0] rep_cnt;
  logic             rep_fire;
  logic             unused_lvl;

  assign unused_lvl = enter_lvl;
  assign rep_fire   = (state == EDIT) && !step_lvl && !step_ev &&
                      (rep_cnt == REP_W'(REPEAT_CYCLES - 1));
  assign step_go    = step_ev | rep_fire;

  // Repeat timer restarts at each real press and runs while step is held in EDIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt <= '0;
    end else if (step_ev || rep_fire || state != EDIT || step_lvl) begin
      rep_cnt <= '0;
    end else begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end
`else
  localparam int unused_repeat = REPEAT_CYCLES;
  logic unused_lvl;

  assign unused_lvl = &{1'b0, step_lvl, enter_lvl};
  assign step_go    = step_ev;
`endif

  // Clamp -8 to +7 when the sign turns positive; wrap limit follows the new sign.
  assign mag_base  = (!sign_s2 && mag == MAX_NEG_MAG) ? MAX_POS : mag;
  assign mag_limit = sign_s2 ? MAX_NEG_MAG : MAX_POS;
  assign editing   = (state == EDIT);

  // Entry FSM: IDLE -> EDIT on step, EDIT -> COMMIT on enter, COMMIT -> IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mag   <= '0;
      neg   <= 1'b0;
      value <= '0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          neg <= sign_s2;
          if (step_go) begin
            state <= EDIT;
            mag   <= 4'd1;
          end else begin
            mag <= '0;
          end
        end
        EDIT: begin
          neg <= sign_s2;
          if (enter_ev) begin
            state <= COMMIT;
            value <= to_twos(mag, neg);
            valid <= 1'b1;
            mag   <= mag_base;
          end else if (step_go) begin
            mag <= (mag_base == mag_limit) ? '0 : mag_base + 1'b1;
          end else begin
            mag <= mag_base;
          end
        end
        COMMIT: begin
          state <= IDLE;
          mag   <= '0;
        end
        default: begin
          state <= IDLE;
          mag   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signed_entry.sv
// Randomized self-checking bench for signed_entry against a behavioural
// model of the entry rules. Honours SIGNED_ENTRY_AUTOREPEAT_EN when defined.
module tb_signed_entry;

  localparam int DB = 4;
  localparam int RP = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] key_n = 2'b11;
  logic       sign_sw = 1'b0;
  logic [3:0] mag;
  logic       neg;
  logic       editing;
  logic [3:0] value;
  logic       valid;

  signed_entry #(.DEBOUNCE_CYCLES(DB), .REPEAT_CYCLES(RP)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_n   (key_n),
    .sign_sw (sign_sw),
    .mag     (mag),
    .neg     (neg),
    .editing (editing),
    .value   (value),
    .valid   (valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Valid pulse monitor: total pulse cycles and longest run.
  int vcount = 0;
  int vrun = 0;
  int vmaxrun = 0;
  always @(posedge clk) begin
    if (valid === 1'b1) begin
      vcount++;
      vrun++;
      if (vrun > vmaxrun) vmaxrun = vrun;
    end else begin
      vrun = 0;
    end
  end

  // Behavioural model of the entry rules.
  int m_mag   = 0;
  bit m_neg   = 0;
  bit m_edit  = 0;
  int m_value = 0;

  function automatic void model_step();
    if (!m_edit) begin
      m_edit = 1;
      m_mag  = 1;
    end else begin
      m_mag = (m_mag == (m_neg ? 8 : 7)) ? 0 : m_mag + 1;
    end
  endfunction

  function automatic void model_sign(bit s);
    m_neg = s;
    if (!s && m_mag == 8) m_mag = 7;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int idx, input int low);
    key_n[idx] = 1'b0;
    tick(low);
    key_n[idx] = 1'b1;
    tick(DB + 4);
  endtask

  task automatic do_step();
    press(0, DB + 3);
    model_step();
    check("step_mag", 32'(mag), 32'(m_mag));
    check("step_editing", 32'(editing), 32'(m_edit));
  endtask

  task automatic set_sign(input bit s);
    sign_sw = s;
    tick(4);
    model_sign(s);
    check("sign_neg", 32'(neg), 32'(s));
    check("sign_mag", 32'(mag), 32'(m_mag));
  endtask

  task automatic do_enter();
    int v0;
    int exp_pulses;
    logic [3:0] ev;
    v0 = vcount;
    exp_pulses = 0;
    press(1, DB + 3);
    if (m_edit) begin
      m_value    = m_neg ? -m_mag : m_mag;
      m_edit     = 0;
      m_mag      = 0;
      exp_pulses = 1;
    end
    ev = m_value[3:0];
    check("enter_value", 32'(value), 32'(ev));
    check("enter_valid_pulses", 32'(vcount - v0), 32'(exp_pulses));
    check("enter_mag", 32'(mag), 32'(0));
    check("enter_editing", 32'(editing), 32'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mag"}, 32'(mag), 32'(0));
    check({tag, "_neg"}, 32'(neg), 32'(0));
    check({tag, "_editing"}, 32'(editing), 32'(0));
    check({tag, "_value"}, 32'(value), 32'(0));
    check({tag, "_valid"}, 32'(valid), 32'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int v0;
    int adv;
    int n;
    bit s;

    // Reset state.
    tick(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    tick(3);
    check_all_zero("post_reset");

    // Enter while idle is ignored; then +3.
    set_sign(1'b0);
    do_enter();
    repeat (3) do_step();
    do_enter();

    // -8, then wrap to -0.
    set_sign(1'b1);
    repeat (8) do_step();
    do_enter();
    repeat (9) do_step();
    do_enter();

    // Clamp -8 to +7 within three cycles of the raw switch change.
    repeat (8) do_step();
    sign_sw = 1'b0;
    tick(3);
    model_sign(1'b0);
    check("clamp_mag", 32'(mag), 32'(m_mag));
    check("clamp_neg", 32'(neg), 32'(0));
    do_enter();

    // Glitch rejection: 3 cycles low is ignored, 6 cycles low is one step.
    do_step();
    key_n[0] = 1'b0;
    tick(3);
    key_n[0] = 1'b1;
    tick(DB + 4);
    check("glitch_mag", 32'(mag), 32'(m_mag));
    press(0, 6);
    model_step();
    check("six_low_mag", 32'(mag), 32'(m_mag));

    // Simultaneous step and enter at mag=2: enter wins.
    check("pre_both_mag", 32'(mag), 32'(2));
    v0 = vcount;
    key_n = 2'b00;
    tick(DB + 3);
    key_n = 2'b11;
    tick(DB + 4);
    m_value = m_mag;
    m_edit  = 0;
    m_mag   = 0;
    check("both_value", 32'(value), 32'(2));
    check("both_pulses", 32'(vcount - v0), 32'(1));
    check("both_mag", 32'(mag), 32'(0));

    // Reset mid-EDIT discards the entry without a valid pulse.
    do_step();
    do_step();
    v0 = vcount;
    rst_n = 1'b0;
    tick(1);
    check_all_zero("midreset");
    m_mag = 0; m_neg = 0; m_edit = 0; m_value = 0;
    rst_n = 1'b1;
    tick(DB + 4);
    check_all_zero("midreset_release");
    check("midreset_pulses", 32'(vcount - v0), 32'(0));

    // Held step key: auto-repeat when enabled, single event otherwise.
`ifdef SIGNED_ENTRY_AUTOREPEAT_EN
    adv = 3;
`else
    adv = 1;
`endif
    set_sign(1'b1);
    do_step();
    key_n[0] = 1'b0;
    tick(DB + 2 + 45);
    key_n[0] = 1'b1;
    tick(DB + 6);
    for (int i = 0; i < adv; i++) model_step();
    check("hold_mag", 32'(mag), 32'(m_mag));
    do_enter();

    // Randomized entries.
    for (int it = 0; it < 12; it++) begin
      s = 1'($urandom_range(0, 1));
      set_sign(s);
      n = $urandom_range(1, 10);
      for (int k = 0; k < n; k++) begin
        do_step();
        if ($urandom_range(0, 7) == 0) set_sign(1'($urandom_range(0, 1)));
      end
      do_enter();
    end

    check("valid_width", 32'(vmaxrun), 32'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/signed_entry.md
SIGNED_ENTRY -- requirements
Module: signed_entry

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000, meaning consecutive stable cycles before a key level is accepted (1 ms at 50 MHz).
REQ-002 SHALL have parameter REPEAT_CYCLES, default 12500000, meaning auto-repeat period of a held step key (used only under REQ-024).
REQ-003 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port key_n  input  2  raw active-low pushbuttons, asynchronous; [0]=step, [1]=enter.
REQ-006 SHALL have port sign_sw  input  1  raw slide switch, asynchronous; 1=negative.
REQ-007 SHALL have port mag  output  4  magnitude being edited, unsigned 0..8.
REQ-008 SHALL have port neg  output  1  current edit sign.
REQ-009 SHALL have port editing  output  1  high while the FSM is in EDIT.
REQ-010 SHALL have port value  output  4  last committed value, two's complement, -8..+7.
REQ-011 SHALL have port valid  output  1  one-cycle pulse when value updates.

Function
REQ-012 SHALL pass key_n and sign_sw through 2-flop synchronizers before any use.
REQ-013 SHALL debounce each key: accept a new level only after DEBOUNCE_CYCLES consecutive equal synchronized samples; a press event is a one-cycle pulse on an accepted 1->0 transition; raw-press-to-event latency is DEBOUNCE_CYCLES+2 cycles; release generates no event.
REQ-014 SHALL implement FSM states IDLE, EDIT, COMMIT.
REQ-015 IDLE: mag=0; step event -> EDIT with mag=1; enter event ignored.
REQ-016 EDIT: step event increments mag; wraps 8->0 when neg=1, 7->0 when neg=0.
REQ-017 neg SHALL track the synchronized sign_sw every cycle in IDLE and EDIT; if neg falls to 0 while mag=8, mag SHALL clamp to 7 in the same cycle.
REQ-018 EDIT: enter event -> COMMIT; value <= neg ? (~mag+1) truncated to 4 bits : mag; -0 commits 4'b0000; -8 commits 4'b1000.
REQ-019 COMMIT SHALL last exactly one cycle with valid=1, then go to IDLE with mag=0; value holds until the next commit.
REQ-020 Simultaneous step and enter events in EDIT: enter wins, step is discarded.
REQ-021 Key events arriving during COMMIT SHALL be dropped.

Reset
REQ-022 rst_n low SHALL immediately force state=IDLE, mag=0, neg=0, editing=0, value=0, valid=0, synchronizer and debounce flops to the released (1) level, debounce counters to 0.
REQ-023 Reset mid-EDIT SHALL discard the partial entry; no valid pulse on reset release.

Configuration
REQ-024 With SIGNED_ENTRY_AUTOREPEAT_EN defined, a step key held pressed in EDIT SHALL produce an extra step event every REPEAT_CYCLES cycles after the initial press event; without it, a held key produces exactly one event.

Structure
REQ-025 Package signed_entry_pkg SHALL hold the FSM state enum, DATA_W=4, MAX_POS=7, MAX_NEG_MAG=8.
REQ-026 Synchronizer plus debounce plus edge detect SHALL be one sub-module, key_debounce, instantiated once per key.

Verification (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=20)
REQ-027 sign_sw=0, 3 step presses, enter -> value=4'b0011, valid high exactly 1 cycle, mag returns to 0.
REQ-028 sign_sw=1, 8 step presses, enter -> value=4'b1000; a 9th press before enter wraps mag to 0 and commits 4'b0000.
REQ-029 sign_sw=1, mag=8, flip sign_sw to 0 -> mag=7 within 3 cycles; enter -> value=4'b0111.
REQ-030 key_n[0] glitching low for 3 cycles -> no event, mag unchanged; low for 6 cycles -> exactly one increment.
REQ-031 step and enter debounced events in the same cycle in EDIT with mag=2 -> value=2, no increment; rst_n pulse mid-EDIT -> all outputs 0, no valid.
REQ-032 With SIGNED_ENTRY_AUTOREPEAT_EN, step held 45 cycles past first event -> mag advances by 3; without it -> by 1.
